// File: rtl/ser_arbiter_if.sv
// Requester and serializer signal bundle for ser_arbiter.
// master: arbiter side; slave: requesters plus serializer.
interface ser_arbiter_if #(
  parameter int NUM_CH         = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_BUS_WIDTH-1:0] req_data_i;
  logic [NUM_CH*DATA_MOD_WIDTH-1:0] req_mod_i;
  logic [NUM_CH-1:0]                req_val_i;
  logic [NUM_CH-1:0]                req_ready_o;
  logic [NUM_CH-1:0]                req_drop_o;
  logic [NUM_CH-1:0]                done_o;
  logic [DATA_BUS_WIDTH-1:0]        ser_data_o;
  logic [DATA_MOD_WIDTH-1:0]        ser_mod_o;
  logic                             ser_val_o;
  logic                             ser_busy_i;
  logic [CH_W-1:0]                  grant_ch_o;
  logic                             grant_val_o;
  logic                             err_o;

  modport master (
    input  req_data_i, req_mod_i,
    input  req_val_i, ser_busy_i,
    output req_ready_o, req_drop_o,
    output done_o, ser_data_o,
    output ser_mod_o, ser_val_o,
    output grant_ch_o, grant_val_o,
    output err_o
  );

  modport slave (
    output req_data_i, req_mod_i,
    output req_val_i, ser_busy_i,
    input  req_ready_o, req_drop_o,
    input  done_o, ser_data_o,
    input  ser_mod_o, ser_val_o,
    input  grant_ch_o, grant_val_o,
    input  err_o
  );
endinterface

// File: rtl/ser_arbiter.sv
// Round-robin arbiter sharing one serializer among NUM_CH requesters.
// Ports: clk_i, arst_n_i (async active-low), bus (ser_arbiter_if.master).
module ser_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  ser_arbiter_if.master bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]         full_q;
  logic [DATA_BUS_WIDTH-1:0] data_q [NUM_CH];
  logic [DATA_MOD_WIDTH-1:0] mod_q  [NUM_CH];
  logic [NUM_CH-1:0]         drop_q;

  logic [CH_W-1:0]           last_q;
  logic [CH_W-1:0]           grant_q;
  logic [DATA_BUS_WIDTH-1:0] sdata_q;
  logic [DATA_MOD_WIDTH-1:0] smod_q;

  logic [NUM_CH-1:0] hs;
  logic [NUM_CH-1:0] bad;
  logic [CH_W-1:0]   win;
  logic              win_val;
  logic              sel;
  logic              fin;
  logic              err;

  // Handshake and illegal-length decode per channel.
  always_comb begin
    hs  = bus.req_val_i & ~full_q;
    bad = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bad[i] =
        (bus.req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH]
          == DATA_MOD_WIDTH'(1)) ||
        (bus.req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH]
          == DATA_MOD_WIDTH'(2));
    end
  end

  // Search full slots from last_q+1, wrapping; the
  // last visited index is last_q itself.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_val = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (!win_val && full_q[idx]) begin
        win     = CH_W'(idx);
        win_val = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    fin     = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_val && !bus.ser_busy_i) begin
          sel     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.ser_busy_i) begin
          state_d = RUN;
        end else begin
          // Serializer never started: report
          // and release the channel anyway.
          err     = 1'b1;
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!bus.ser_busy_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      last_q  <= LAST_CH;
      grant_q <= '0;
      sdata_q <= '0;
      smod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (sel) begin
        last_q  <= win;
        grant_q <= win;
        sdata_q <= data_q[win];
        smod_q  <= mod_q[win];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      full_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
        mod_q[i]  <= '0;
      end
    end else begin
      drop_q <= hs & bad;
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == ISSUE &&
            grant_q == CH_W'(i)) begin
          full_q[i] <= 1'b0;
        end else if (hs[i] && !bad[i]) begin
          full_q[i] <= 1'b1;
          data_q[i] <= bus.req_data_i[
            i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
          mod_q[i]  <= bus.req_mod_i[
            i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
        end
      end
    end
  end

  always_comb begin
    bus.done_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.done_o[i] = fin && (grant_q == CH_W'(i));
    end
  end

  assign bus.req_ready_o = ~full_q;
  assign bus.req_drop_o  = drop_q;
  assign bus.ser_data_o  = sdata_q;
  assign bus.ser_mod_o   = smod_q;
  assign bus.ser_val_o   = (state_q == ISSUE);
  assign bus.grant_ch_o  = grant_q;
  assign bus.grant_val_o = (state_q != IDLE);
  assign bus.err_o       = err;

endmodule

// File: tb/tb_ser_arbiter.sv
// Self-checking bench for ser_arbiter with a behavioural
// serializer and a round-robin scoreboard.
module tb_ser_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 4;

  logic clk;
  logic arst_n;

  int n_chk;
  int n_fail;

  ser_arbiter_if #(
    .NUM_CH(N),
    .DATA_BUS_WIDTH(DW),
    .DATA_MOD_WIDTH(MW)
  ) bus ();

  ser_arbiter #(
    .NUM_CH(N),
    .DATA_BUS_WIDTH(DW),
    .DATA_MOD_WIDTH(MW)
  ) dut (
    .clk_i(clk),
    .arst_n_i(arst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: one bit per cycle while busy.
  int   ser_cnt;
  logic ser_ignore;
  logic busy_force;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ser_cnt <= 0;
    end else if (ser_cnt != 0) begin
      ser_cnt <= ser_cnt - 1;
    end else if (bus.ser_val_o && !ser_ignore &&
                 bus.ser_mod_o != 4'd1 &&
                 bus.ser_mod_o != 4'd2) begin
      ser_cnt <= (bus.ser_mod_o == 4'd0) ?
                 DW : int'(bus.ser_mod_o);
    end
  end

  assign bus.ser_busy_i = (ser_cnt != 0) | busy_force;

  // Last channel actually issued, for RR expectations.
  int last_gnt;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) last_gnt <= N - 1;
    else if (bus.ser_val_o)
      last_gnt <= int'(bus.grant_ch_o);
  end

  function automatic int rr_pick(
    input logic [N-1:0] p,
    input int           last
  );
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(
    input int        c,
    input logic      v,
    input [DW-1:0]   d,
    input [MW-1:0]   m
  );
    bus.req_val_i[c]          = v;
    bus.req_data_i[c*DW +: DW] = d;
    bus.req_mod_i[c*MW +: MW]  = m;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.grant_val_o && !bus.ser_busy_i &&
          bus.req_ready_o == '1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if (bus.req_ready_o !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 1111",
               bus.req_ready_o);
    end
    n_chk++;
    if (bus.ser_val_o !== 1'b0 ||
        bus.grant_val_o !== 1'b0 ||
        bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl got val=%b gv=%b err=%b want 0",
               bus.ser_val_o, bus.grant_val_o, bus.err_o);
    end
    n_chk++;
    if (bus.done_o !== 4'h0 ||
        bus.req_drop_o !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_pulse got done=%b drop=%b want 0",
               bus.done_o, bus.req_drop_o);
    end
    n_chk++;
    if (bus.ser_data_o !== 16'h0 ||
        bus.ser_mod_o !== 4'h0 ||
        bus.grant_ch_o !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_bus got d=%h m=%h g=%0d want 0",
               bus.ser_data_o, bus.ser_mod_o,
               bus.grant_ch_o);
    end
  endtask

  task automatic test_single();
    int  bits;
    bit  got;
    @(posedge clk); #1;
    set_req(2, 1'b1, 16'hA5C3, 4'd0);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready got %b want 1",
               bus.req_ready_o[2]);
    end
    @(posedge clk); #1;
    bus.req_val_i = '0;
    @(negedge clk);
    n_chk++;
    if (bus.ser_val_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early got %b want 0",
               bus.ser_val_o);
    end
    @(negedge clk);
    n_chk++;
    if (bus.ser_val_o !== 1'b1 ||
        bus.ser_data_o !== 16'hA5C3 ||
        bus.ser_mod_o !== 4'd0 ||
        bus.grant_ch_o !== 2'd2) begin
      n_fail++;
      $display("FAIL single_issue got v=%b d=%h m=%0d g=%0d want 1 a5c3 0 2",
               bus.ser_val_o, bus.ser_data_o,
               bus.ser_mod_o, bus.grant_ch_o);
    end
    bits = 0;
    got  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o != 0) begin
        got = 1'b1;
        break;
      end
      if (bus.ser_busy_i) bits++;
    end
    n_chk++;
    if (!got || bus.done_o !== 4'b0100 ||
        bus.ser_busy_i !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done got %b want 0100",
               bus.done_o);
    end
    n_chk++;
    if (bits != 16) begin
      n_fail++;
      $display("FAIL single_bits got %0d want 16", bits);
    end
    n_chk++;
    if (bus.ser_data_o !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL single_hold got %h want a5c3",
               bus.ser_data_o);
    end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] d [N];
    int  n;
    int  exp;
    bit  ok;
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin
      d[c] = DW'($urandom);
      set_req(c, 1'b1, d[c], 4'd8);
    end
    n = 0;
    for (int i = 0; i < 300 && n < 8; i++) begin
      @(negedge clk);
      if (bus.ser_val_o) begin
        exp = (last_gnt + 1) % N;
        n_chk++;
        if (int'(bus.grant_ch_o) != exp ||
            bus.ser_data_o !== d[exp] ||
            bus.ser_mod_o !== 4'd8) begin
          n_fail++;
          $display("FAIL fair_grant got %0d/%h want %0d/%h",
                   bus.grant_ch_o, bus.ser_data_o,
                   exp, d[exp]);
        end
        n++;
      end
    end
    n_chk++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL fair_count got %0d want 8", n);
    end
    @(posedge clk); #1;
    bus.req_val_i = '0;
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fair_drain got busy want idle");
    end
  endtask

  task automatic test_illegal();
    logic [MW-1:0] m;
    for (int r = 1; r <= 2; r++) begin
      m = MW'(r);
      @(posedge clk); #1;
      set_req(1, 1'b1, 16'h1234, m);
      @(negedge clk);
      n_chk++;
      if (bus.req_ready_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL ill_ready got %b want 1",
                 bus.req_ready_o[1]);
      end
      @(posedge clk); #1;
      bus.req_val_i = '0;
      @(negedge clk);
      n_chk++;
      if (bus.req_drop_o !== 4'b0010 ||
          bus.req_ready_o !== 4'hF ||
          bus.ser_val_o !== 1'b0) begin
        n_fail++;
        $display("FAIL ill_drop mod=%0d got drop=%b rdy=%b v=%b want 0010 1111 0",
                 r, bus.req_drop_o, bus.req_ready_o,
                 bus.ser_val_o);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_chk++;
        if (bus.ser_val_o !== 1'b0 ||
            bus.req_drop_o !== 4'h0) begin
          n_fail++;
          $display("FAIL ill_quiet got v=%b drop=%b want 0",
                   bus.ser_val_o, bus.req_drop_o);
        end
      end
    end
  endtask

  task automatic test_gating();
    bit ok;
    @(posedge clk); #1;
    busy_force = 1'b1;
    set_req(0, 1'b1, 16'h0F0F, 4'd4);
    @(posedge clk); #1;
    bus.req_val_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.ser_val_o !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_hold got %b want 0",
                 bus.ser_val_o);
      end
    end
    @(posedge clk); #1;
    busy_force = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.ser_val_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_sel got %b want 0",
               bus.ser_val_o);
    end
    @(negedge clk);
    n_chk++;
    if (bus.ser_val_o !== 1'b1 ||
        bus.grant_ch_o !== 2'd0 ||
        bus.ser_data_o !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL gate_issue got v=%b g=%0d d=%h want 1 0 0f0f",
               bus.ser_val_o, bus.grant_ch_o,
               bus.ser_data_o);
    end
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL gate_drain got busy want idle");
    end
  endtask

  task automatic test_watchdog();
    bit got;
    @(posedge clk); #1;
    ser_ignore = 1'b1;
    set_req(3, 1'b1, 16'hBEEF, 4'd5);
    @(posedge clk); #1;
    bus.req_val_i = '0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ser_val_o) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    n_chk++;
    if (!got || bus.err_o !== 1'b1 ||
        bus.done_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL wdog_pulse got err=%b done=%b want 1 1000",
               bus.err_o, bus.done_o);
    end
    @(negedge clk);
    n_chk++;
    if (bus.err_o !== 1'b0 || bus.done_o !== 4'h0 ||
        bus.grant_val_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_idle got err=%b done=%b gv=%b want 0",
               bus.err_o, bus.done_o, bus.grant_val_o);
    end
    @(posedge clk); #1;
    ser_ignore = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit got;
    @(posedge clk); #1;
    set_req(1, 1'b1, 16'h5555, 4'd0);
    @(posedge clk); #1;
    bus.req_val_i = '0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    n_chk++;
    if (bus.grant_val_o !== 1'b1 ||
        bus.ser_busy_i !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run got gv=%b busy=%b want 1 1",
               bus.grant_val_o, bus.ser_busy_i);
    end
    #2 arst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.grant_val_o !== 1'b0 ||
        bus.ser_val_o !== 1'b0 ||
        bus.req_ready_o !== 4'hF ||
        bus.ser_data_o !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_clear got gv=%b v=%b rdy=%b d=%h want 0 0 1111 0",
               bus.grant_val_o, bus.ser_val_o,
               bus.req_ready_o, bus.ser_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.done_o !== 4'h0) begin
        n_fail++;
        $display("FAIL mid_nodone got %b want 0",
                 bus.done_o);
      end
    end
    arst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0A0A, 4'd3);
    set_req(2, 1'b1, 16'h2B2B, 4'd3);
    @(posedge clk); #1;
    bus.req_val_i = '0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ser_val_o) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!got || bus.grant_ch_o !== 2'd0 ||
        bus.ser_data_o !== 16'h0A0A) begin
      n_fail++;
      $display("FAIL mid_first got %0d/%h want 0/0a0a",
               bus.grant_ch_o, bus.ser_data_o);
    end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.ser_val_o) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!got || bus.grant_ch_o !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_second got %0d want 2",
               bus.grant_ch_o);
    end
    wait_idle(got);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_drain got busy want idle");
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  pend;
    logic [N-1:0]  pend_prev;
    logic [N-1:0]  exp_drop;
    logic [DW-1:0] md [N];
    logic [MW-1:0] mm [N];
    int  outst;
    int  issues;
    int  dones;
    int  exp;
    int  clr;
    bit  fin;
    pend      = '0;
    pend_prev = '0;
    exp_drop  = '0;
    outst     = -1;
    issues    = 0;
    dones     = 0;
    fin       = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) begin
        if (cyc < 500)
          set_req(c, $urandom_range(0, 2) == 0,
                  DW'($urandom),
                  MW'($urandom_range(0, 15)));
        else
          set_req(c, 1'b0, '0, '0);
      end
      @(negedge clk);
      clr = -1;
      if (bus.ser_val_o) begin
        exp = rr_pick(pend_prev, last_gnt);
        n_chk++;
        if (exp < 0 ||
            int'(bus.grant_ch_o) != exp ||
            bus.ser_data_o !== md[exp] ||
            bus.ser_mod_o !== mm[exp]) begin
          n_fail++;
          $display("FAIL rnd_issue got %0d/%h/%0d want %0d",
                   bus.grant_ch_o, bus.ser_data_o,
                   bus.ser_mod_o, exp);
        end
        if (exp >= 0) begin
          clr   = exp;
          outst = exp;
        end
        issues++;
      end
      n_chk++;
      if (bus.req_ready_o !== ~pend) begin
        n_fail++;
        $display("FAIL rnd_ready got %b want %b",
                 bus.req_ready_o, ~pend);
      end
      n_chk++;
      if (bus.req_drop_o !== exp_drop ||
          bus.err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_drop got %b err=%b want %b",
                 bus.req_drop_o, bus.err_o, exp_drop);
      end
      if (bus.done_o != 0) begin
        n_chk++;
        if (outst < 0 ||
            bus.done_o !== (4'b1 << outst)) begin
          n_fail++;
          $display("FAIL rnd_done got %b want ch %0d",
                   bus.done_o, outst);
        end
        outst = -1;
        dones++;
      end
      pend_prev = pend;
      exp_drop  = '0;
      for (int c = 0; c < N; c++) begin
        if (bus.req_val_i[c] && !pend[c]) begin
          if (bus.req_mod_i[c*MW +: MW] == 4'd1 ||
              bus.req_mod_i[c*MW +: MW] == 4'd2) begin
            exp_drop[c] = 1'b1;
          end else begin
            pend[c] = 1'b1;
            md[c]   = bus.req_data_i[c*DW +: DW];
            mm[c]   = bus.req_mod_i[c*MW +: MW];
          end
        end
      end
      if (clr >= 0) pend[clr] = 1'b0;
      if (cyc > 500 && pend == 0 && outst < 0 &&
          !bus.grant_val_o) begin
        fin = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!fin || issues != dones || issues == 0) begin
      n_fail++;
      $display("FAIL rnd_end got fin=%b iss=%0d done=%0d want equal",
               fin, issues, dones);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    ser_ignore = 1'b0;
    busy_force = 1'b0;
    bus.req_val_i  = '0;
    bus.req_data_i = '0;
    bus.req_mod_i  = '0;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_illegal();
    test_gating();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
